// File: rtl/intpol2_d4_ch_sched_pkg.sv
// Shared constants for the two-channel interpolator job scheduler:
// channel count, FSM state encoding and a channel-to-one-hot helper.
package intpol2_D4_pkg;

  localparam int unsigned NUM_CH = 2;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GRANT     = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_RELEASE   = 3'd5;

  function automatic logic [NUM_CH-1:0] ch_bit(input logic ch);
    ch_bit     = '0;
    ch_bit[ch] = 1'b1;
  endfunction

endpackage

// File: rtl/intpol2_d4_rr_arb.sv
// Two-way round-robin pick: the channel that did not own the last job wins a tie.
import intpol2_D4_pkg::*;

module intpol2_d4_rr_arb (
  input  logic [NUM_CH-1:0] req,
  input  logic              last_ch,
  output logic              grant,
  output logic              valid
);

  logic pref;

  always_comb begin
    pref  = ~last_ch;
    valid = |req;
    grant = req[pref] ? pref : ~pref;
  end

endmodule

// File: rtl/intpol2_d4_ch_sched.sv
// Job scheduler sharing one interpolator core between two channels:
// arbitrates requests, latches job config, starts the core and reports completion.
import intpol2_D4_pkg::*;

module intpol2_d4_ch_sched #(
  parameter int unsigned CONFIG_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       req,
  input  logic [CONFIG_WIDTH-1:0] ch0_ilen,
  input  logic [CONFIG_WIDTH-1:0] ch1_ilen,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH-1:0]       ch_bypass,
  input  logic [CONFIG_WIDTH-1:0] timeout_cycles,
  input  logic                    abort,
  input  logic                    core_busy,
  input  logic                    core_done,
  output logic                    core_start,
  output logic [CONFIG_WIDTH-1:0] core_ilen,
  output logic                    core_mode,
  output logic                    core_bypass,
  output logic                    sel_ch,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_err,
  output logic                    active
);

  logic [2:0]              state_q, state_d;
  logic                    win_q, win_d, last_q, last_d, sel_q, sel_d;
  logic [CONFIG_WIDTH-1:0] ilen_q, ilen_d, cnt_q, cnt_d;
  logic                    mode_q, mode_d, byp_q, byp_d, start_q, start_d;
  logic [NUM_CH-1:0]       ack_q, ack_d, done_q, done_d, err_q, err_d;

  logic                    arb_grant, arb_valid, wd_hit;
  logic [CONFIG_WIDTH-1:0] win_ilen, cnt_inc;

  intpol2_d4_rr_arb u_arb (
    .req     (req),
    .last_ch (last_q),
    .grant   (arb_grant),
    .valid   (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    sel_d    = sel_q;
    ilen_d   = ilen_q;
    mode_d   = mode_q;
    byp_d    = byp_q;
    cnt_d    = cnt_q;
    start_d  = 1'b0;
    ack_d    = '0;
    done_d   = '0;
    err_d    = '0;
    win_ilen = win_q ? ch1_ilen : ch0_ilen;
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CONFIG_WIDTH'(1);
    // cnt_inc counts the current cycle, so the error lands timeout_cycles after core_start
    wd_hit   = (timeout_cycles != '0) && (cnt_inc >= timeout_cycles);

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d   = arb_grant;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[win_q]) begin
          state_d = ST_IDLE;
        end else begin
          ilen_d = win_ilen;
          mode_d = ch_mode[win_q];
          byp_d  = ch_bypass[win_q];
          sel_d  = win_q;
          ack_d  = ch_bit(win_q);
          if (win_ilen == '0) begin
            err_d   = ch_bit(win_q);
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY, ST_RUN: begin
        cnt_d = cnt_inc;
        if (core_done) begin
          done_d  = ch_bit(sel_q);
          state_d = ST_RELEASE;
        end else if (abort || wd_hit) begin
          err_d   = ch_bit(sel_q);
          state_d = ST_RELEASE;
        end else if (state_q == ST_WAIT_BUSY && core_busy) begin
          state_d = ST_RUN;
        end
      end
      ST_RELEASE: begin
        last_d = sel_q;
        if (!core_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      ilen_q  <= '0;
      mode_q  <= 1'b0;
      byp_q   <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      ilen_q  <= ilen_d;
      mode_q  <= mode_d;
      byp_q   <= byp_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign core_start  = start_q;
  assign core_ilen   = ilen_q;
  assign core_mode   = mode_q;
  assign core_bypass = byp_q;
  assign sel_ch      = sel_q;
  assign ack         = ack_q;
  assign ch_done     = done_q;
  assign ch_err      = err_q;
  assign active      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_intpol2_d4_ch_sched.sv
// Directed job table plus a reset-in-RUN sequence for the two-channel scheduler.
module tb_intpol2_d4_ch_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] ch0_ilen = '0, ch1_ilen = '0, timeout_cycles = '0;
  logic [1:0]  ch_mode = '0, ch_bypass = '0;
  logic        abort = 1'b0, core_busy = 1'b0, core_done = 1'b0;
  logic        core_start, core_mode, core_bypass, sel_ch, active;
  logic [31:0] core_ilen;
  logic [1:0]  ack, ch_done, ch_err;

  int checks = 0;
  int errors = 0;

  intpol2_d4_ch_sched #(.CONFIG_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .ch0_ilen(ch0_ilen), .ch1_ilen(ch1_ilen),
    .ch_mode(ch_mode), .ch_bypass(ch_bypass), .timeout_cycles(timeout_cycles),
    .abort(abort), .core_busy(core_busy), .core_done(core_done),
    .core_start(core_start), .core_ilen(core_ilen), .core_mode(core_mode),
    .core_bypass(core_bypass), .sel_ch(sel_ch), .ack(ack), .ch_done(ch_done),
    .ch_err(ch_err), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] ilen0, ilen1, tmo;
    logic [1:0]  mode, byp;
    int          B, D, H, A;
    bit          keep;
    logic [1:0]  e_ack, e_done, e_err;
    logic [31:0] e_ilen;
    logic        e_sel, e_mode, e_byp;
    int          e_starts, e_evt, e_idle;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(logic [1:0] rq, logic [31:0] i0, logic [31:0] i1, logic [31:0] tmo,
                              logic [1:0] md, logic [1:0] bp, int B, int D, int H, int A, bit keep,
                              logic [1:0] ea, logic [1:0] ed, logic [1:0] ee, logic [31:0] eil,
                              logic es, logic em, logic eb, int est, int eev, int eid);
    vec_t v;
    v.req = rq; v.ilen0 = i0; v.ilen1 = i1; v.tmo = tmo; v.mode = md; v.byp = bp;
    v.B = B; v.D = D; v.H = H; v.A = A; v.keep = keep;
    v.e_ack = ea; v.e_done = ed; v.e_err = ee; v.e_ilen = eil;
    v.e_sel = es; v.e_mode = em; v.e_byp = eb;
    v.e_starts = est; v.e_evt = eev; v.e_idle = eid;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int s = -1, evt = -1, idle = -1, starts = 0, ack_cnt = 0;
    bit busy_off = 0;
    logic [1:0] ack_or = '0, done_or = '0, err_or = '0;
    ch0_ilen = v.ilen0; ch1_ilen = v.ilen1; timeout_cycles = v.tmo;
    ch_mode = v.mode; ch_bypass = v.byp; req = v.req; abort = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (core_start) begin
        starts++;
        if (s < 0) s = k;
      end
      if (ack != 2'b00) begin
        ack_cnt++;
        ack_or |= ack;
        if (!v.keep) req = req & ~ack;
      end
      done_or |= ch_done;
      err_or  |= ch_err;
      if (k == 2) begin
        check($sformatf("v%0d ack", idx), 64'(ack), 64'(v.e_ack));
        check($sformatf("v%0d sel_ch", idx), 64'(sel_ch), 64'(v.e_sel));
        check($sformatf("v%0d core_ilen", idx), 64'(core_ilen), 64'(v.e_ilen));
        check($sformatf("v%0d mode/bypass", idx), 64'({core_mode, core_bypass}),
              64'({v.e_mode, v.e_byp}));
      end
      if ((ch_done | ch_err) != 2'b00 && evt < 0) evt = k;
      if (!active && k > 1) begin
        idle = k;
        check($sformatf("v%0d core_ilen hold", idx), 64'(core_ilen), 64'(v.e_ilen));
        break;
      end
      // bench-side core: busy after B, done pulse after B+D, else drop busy H after the event
      abort     = (v.A > 0 && k == v.A);
      core_done = 1'b0;
      if (s >= 0 && !busy_off) begin
        if (v.D > 0 && k == s + v.B + v.D) begin
          core_done = 1'b1; core_busy = 1'b0; busy_off = 1;
        end else if (v.D == 0 && evt >= 0 && k == evt + v.H) begin
          core_busy = 1'b0; busy_off = 1;
        end else if (k >= s + v.B) begin
          core_busy = 1'b1;
        end
      end
    end
    check($sformatf("v%0d idle step", idx), 64'(idle), 64'(v.e_idle));
    check($sformatf("v%0d start count", idx), 64'(starts), 64'(v.e_starts));
    if (v.e_starts > 0) check($sformatf("v%0d start step", idx), 64'(s), 64'(3));
    check($sformatf("v%0d ack pulses", idx), 64'(ack_cnt), 64'(1));
    check($sformatf("v%0d ack or", idx), 64'(ack_or), 64'(v.e_ack));
    check($sformatf("v%0d ch_done", idx), 64'(done_or), 64'(v.e_done));
    check($sformatf("v%0d ch_err", idx), 64'(err_or), 64'(v.e_err));
    check($sformatf("v%0d event step", idx), 64'(evt), 64'(v.e_evt));
    if (!v.keep) req = '0;
    abort = 1'b0; core_done = 1'b0; core_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [1:0] pulses;
    //            req    ilen0  ilen1  tmo   mode   byp    B  D   H  A  keep  ack    done   err    ilen sel md bp st evt idle
    tbl[0] = mk(2'b01, 32'd16, 32'd5,  32'd0, 2'b01, 2'b00, 2, 20, 0, 0, 0, 2'b01, 2'b01, 2'b00, 32'd16, 0, 1, 0, 1, 26, 27);
    tbl[1] = mk(2'b10, 32'd9,  32'd7,  32'd0, 2'b00, 2'b10, 1, 3,  0, 0, 0, 2'b10, 2'b10, 2'b00, 32'd7,  1, 0, 1, 1, 8,  9);
    tbl[2] = mk(2'b10, 32'd9,  32'd0,  32'd0, 2'b11, 2'b00, 1, 3,  0, 0, 0, 2'b10, 2'b00, 2'b10, 32'd0,  1, 1, 0, 0, 2,  3);
    tbl[3] = mk(2'b01, 32'd4,  32'd6,  32'd10,2'b00, 2'b00, 2, 0,  5, 0, 0, 2'b01, 2'b00, 2'b01, 32'd4,  0, 0, 0, 1, 13, 19);
    tbl[4] = mk(2'b10, 32'd4,  32'd3,  32'd0, 2'b00, 2'b00, 1, 0,  2, 8, 0, 2'b10, 2'b00, 2'b10, 32'd3,  1, 0, 0, 1, 9,  12);
    tbl[5] = mk(2'b01, 32'd2,  32'd3,  32'd0, 2'b00, 2'b00, 1, 4,  0, 8, 0, 2'b01, 2'b01, 2'b00, 32'd2,  0, 0, 0, 1, 9,  10);
    tbl[6] = mk(2'b10, 32'd2,  32'd1,  32'd4, 2'b00, 2'b00, 1, 2,  0, 0, 0, 2'b10, 2'b10, 2'b00, 32'd1,  1, 0, 0, 1, 7,  8);
    tbl[7] = mk(2'b11, 32'd11, 32'd12, 32'd0, 2'b10, 2'b01, 1, 1,  0, 0, 1, 2'b01, 2'b01, 2'b00, 32'd11, 0, 0, 1, 1, 6,  7);
    tbl[8] = mk(2'b11, 32'd11, 32'd12, 32'd0, 2'b10, 2'b01, 1, 1,  0, 0, 1, 2'b10, 2'b10, 2'b00, 32'd12, 1, 1, 0, 1, 6,  7);
    tbl[9] = mk(2'b11, 32'd11, 32'd12, 32'd0, 2'b10, 2'b01, 1, 1,  0, 0, 0, 2'b01, 2'b01, 2'b00, 32'd11, 0, 0, 1, 1, 6,  7);

    #1;
    check("reset outputs", 64'({core_start, core_ilen, core_mode, core_bypass, sel_ch,
                               ack, ch_done, ch_err, active}), 64'(0));
    step();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, tbl[i]);

    // reset in RUN: last owner was ch0, so without reset ch1 would win the next tie
    ch0_ilen = 32'd8; ch1_ilen = 32'd9; timeout_cycles = '0; req = 2'b11;
    step(); step();
    check("pre-rst ack", 64'(ack), 64'(2'b10));
    req = 2'b01;
    step();
    check("pre-rst start", 64'(core_start), 64'(1));
    core_busy = 1'b1;
    step();
    step();
    check("pre-rst active", 64'(active), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("rst async outputs", 64'({core_start, core_ilen, core_mode, core_bypass, sel_ch,
                                   ack, ch_done, ch_err, active}), 64'(0));
    req = '0; core_busy = 1'b0;
    pulses = '0;
    step(); pulses |= ch_done | ch_err;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      pulses |= ch_done | ch_err;
    end
    check("no pulse after rst", 64'(pulses), 64'(0));
    req = 2'b11;
    step(); step();
    check("post-rst ack ch0", 64'(ack), 64'(2'b01));
    check("post-rst sel_ch", 64'(sel_ch), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/intpol2_d4_ch_sched.md
INTPOL2_D4_CH_SCHED -- requirements
Module: intpol2_d4_ch_sched

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 32, width of ilen and timeout fields.
REQ-002 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have req  input  2  per-channel job request, level, held until ack.
REQ-005 SHALL have ch0_ilen, ch1_ilen  input  CONFIG_WIDTH each  per-channel job length in samples.
REQ-006 SHALL have ch_mode, ch_bypass  input  2 each  per-channel mode/bypass bit (bit i = channel i).
REQ-007 SHALL have timeout_cycles  input  CONFIG_WIDTH  job watchdog limit, 0 = disabled.
REQ-008 SHALL have abort  input  1  kill current job.
REQ-009 SHALL have core_busy, core_done  input  1 each  status from interpolator core.
REQ-010 SHALL have core_start  output  1  one-cycle start pulse to core.
REQ-011 SHALL have core_ilen  output  CONFIG_WIDTH; core_mode, core_bypass  output  1 each  registered job config.
REQ-012 SHALL have sel_ch  output  1  owning channel, steers FIFO/memory muxes.
REQ-013 SHALL have ack, ch_done, ch_err  output  2 each  per-channel one-cycle pulses.
REQ-014 SHALL have active  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, GRANT, START, WAIT_BUSY, RUN, RELEASE.
REQ-016 IDLE: on any req bit set, SHALL pick winner by round-robin (priority to channel != last_ch; if only one requests, that one) and go GRANT.
REQ-017 GRANT (1 cycle): SHALL latch winner ilen/mode/bypass into core_* and set sel_ch = winner; SHALL pulse ack[winner].
REQ-018 GRANT with latched ilen == 0: SHALL pulse ch_err[winner] with ack, skip core, go RELEASE.
REQ-019 START: SHALL assert core_start for exactly one cycle, clear watchdog counter, go WAIT_BUSY.
REQ-020 WAIT_BUSY: core_busy=1 -> RUN; core_done=1 (even with core_busy=0) -> RELEASE with ch_done pulse.
REQ-021 RUN: core_done=1 -> pulse ch_done[sel_ch], go RELEASE.
REQ-022 Watchdog: counter SHALL increment each cycle in WAIT_BUSY/RUN, saturating; when timeout_cycles != 0 and count >= timeout_cycles, SHALL pulse ch_err[sel_ch], go RELEASE.
REQ-023 abort in WAIT_BUSY/RUN SHALL pulse ch_err[sel_ch], go RELEASE; abort ignored in other states.
REQ-024 Simultaneous core_done and timeout/abort: done SHALL win (ch_done only, no ch_err).
REQ-025 RELEASE: SHALL update last_ch = sel_ch; leave to IDLE only when core_busy = 0, else hold.
REQ-026 core_* and sel_ch SHALL stay stable from GRANT through RELEASE; at most one of ack/ch_done/ch_err bits high per channel per cycle except the REQ-018 case.
REQ-027 A req dropped before ack SHALL be ignored; req changes during a job SHALL not affect core_*.
REQ-028 Grant-to-core_start latency SHALL be 1 cycle; req-to-ack latency 2 cycles from IDLE.

Reset
REQ-029 rst SHALL force IDLE, last_ch=1 (channel 0 wins first tie), counter=0, all outputs 0, immediately and asynchronously.
REQ-030 rst mid-job SHALL abandon job with no ch_done/ch_err pulse.

Structure
REQ-031 State encoding and channel count constant (2) SHALL reside in shared package intpol2_D4_pkg.
REQ-032 Round-robin pick SHALL be sub-module intpol2_d4_rr_arb (2-bit req, last_ch -> grant index, valid).
REQ-033 Target size 150-300 RTL lines; single clock domain, no latches.

Verification
REQ-034 req=01, ch0_ilen=16, core_busy 2 cycles after start, core_done 20 cycles later -> ack=01, one core_start, core_ilen=16, ch_done=01, back to IDLE.
REQ-035 req=11 held through 3 jobs -> grants ch0, ch1, ch0; sel_ch matches each job.
REQ-036 timeout_cycles=10, core never done -> ch_err[sel_ch] 10 cycles after start, RELEASE holds while core_busy=1.
REQ-037 ch1_ilen=0, req=10 -> ack=10 and ch_err=10 same cycle, core_start never asserted.
REQ-038 abort and core_done in same RUN cycle -> ch_done only; abort alone -> ch_err only.
REQ-039 rst asserted in RUN -> all outputs 0 same cycle, no pulses, next req granted to ch0.
